seq_summer: RTL and testbench
=============================

SEQ_SUMMER -- requirements
Module: seq_summer

Interface
- REQ-001: The block SHALL take parameter W, default 8, as the data width of inA and sum.
- REQ-002: The block SHALL take parameter CW, default 8, as the width of the term counter nterms.
- REQ-003: ck  input  1  SHALL be the sole clock; all state updates on its rising edge.
- REQ-004: reset  input  1  SHALL be the reset, asynchronous and active-high.
- REQ-005: go_l  input  1  SHALL be the active-low start, sampled only in IDLE.
- REQ-006: inA  input  W  SHALL be the value stream, one term per cycle; a value of 0 terminates the sequence.
- REQ-007: sum  output  W  SHALL be the registered running/final sum.
- REQ-008: done  output  1  SHALL be a registered one-cycle pulse marking a final, valid sum (drives the downstream load).
- REQ-009: busy  output  1  SHALL be high in ACCUM and DONE.
- REQ-010: nterms  output  CW  SHALL be the count of nonzero terms summed.
- REQ-011: ovf  output  1  SHALL exist only when SEQ_SUMMER_SAT_EN is defined.

Function
- REQ-012: The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
- REQ-013: IDLE & go_l=1 SHALL hold all outputs and stay in IDLE.
- REQ-014: IDLE & go_l=0 & inA!=0 SHALL set sum<=inA and nterms<=1, then go to ACCUM.
- REQ-015: IDLE & go_l=0 & inA=0 SHALL set sum<=0 and nterms<=0, then go to DONE.
- REQ-016: ACCUM & inA!=0 SHALL set sum<=sum+inA and nterms<=nterms+1, and stay in ACCUM.
- REQ-017: ACCUM & inA=0 SHALL leave sum and nterms unchanged and go to DONE.
- REQ-018: In DONE, done=1 for exactly one cycle, sum and nterms SHALL be held, and the next state SHALL be IDLE unconditionally.
- REQ-019: go_l SHALL be ignored in ACCUM and DONE; a go_l=0 seen in DONE SHALL NOT start a new sequence.
- REQ-020: Latency SHALL be: the zero term at edge N gives done=1 in cycle N+1; the earliest restart is go_l=0 sampled at edge N+2.
- REQ-021: After DONE, sum SHALL stay stable in IDLE until the next accepted go_l.
- REQ-022: nterms SHALL saturate at 2^CW-1 and never wrap.
- REQ-023: Arithmetic SHALL be unsigned, W bits; without the macro, sum wraps modulo 2^W.

Reset
- REQ-024: Reset assertion SHALL immediately force state=IDLE, sum=0, nterms=0, done=0, busy=0 and ovf=0, including mid-sequence.
- REQ-025: After reset deassertion, the block SHALL accept go_l on the first rising edge.

Configuration
- REQ-026: With SEQ_SUMMER_SAT_EN defined, each add SHALL clamp sum at 2^W-1, ovf SHALL be set on any clamping add, ovf SHALL stay sticky through DONE, and ovf SHALL clear only on an accepted go_l or on reset.
- REQ-027: Without SEQ_SUMMER_SAT_EN, there SHALL be no ovf port, the adder SHALL wrap, and there SHALL be no saturation logic.

Structure
- REQ-028: Package seq_summer_pkg SHALL hold the state enum (IDLE, ACCUM, DONE) and the default constants for W and CW.
- REQ-029: Sub-module seq_summer_add SHALL be the W-bit adder with carry-out and optional clamping under SEQ_SUMMER_SAT_EN; all other logic SHALL stay in seq_summer.

Verification
- REQ-030: Basic sum: go_l=0 with inA=3, then 5, 7, 0 (W=8) -> done pulses one cycle after the 0, sum=15, nterms=3.
- REQ-031: Immediate zero: go_l=0 with inA=0 -> done next cycle, sum=0, nterms=0, busy high for exactly one cycle.
- REQ-032: Wrap (macro off): 200, 100, 0 -> sum=44, nterms=2.
- REQ-033: Saturate (macro on): 200, 100, 0 -> sum=255, ovf=1 through DONE; the next go_l clears ovf.
- REQ-034: Reset mid-op: reset during ACCUM after 9, 9 -> sum=0, state IDLE, no done pulse; a fresh 4, 0 then gives sum=4.
- REQ-035: Go ignored while busy: go_l held low through ACCUM and DONE -> a single done pulse, and a new sequence starts only at the IDLE edge after DONE.

Source files
------------

// File: rtl/seq_summer_pkg.sv
// Shared constants and state encoding for the sequence summer.
// Saturating arithmetic is enabled by defining SEQ_SUMMER_SAT_EN.
package seq_summer_pkg;

    localparam int unsigned WDefault  = 8;
    localparam int unsigned CwDefault = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ACCUM = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/seq_summer_add.sv
// W-bit unsigned adder with carry-out; clamps to all-ones on carry when
// SEQ_SUMMER_SAT_EN is defined, wraps otherwise.
module seq_summer_add
    import seq_summer_pkg::*;
#(
    parameter int unsigned W = WDefault
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);

    logic [W:0] full;

    assign full    = {1'b0, a_i} + {1'b0, b_i};
    assign carry_o = full[W];

`ifdef SEQ_SUMMER_SAT_EN
    assign sum_o = carry_o ? {W{1'b1}} : full[W-1:0];
`else
    assign sum_o = full[W-1:0];
`endif

endmodule

// File: rtl/seq_summer.sv
// Sums a zero-terminated stream of terms started by an active-low go.
// Defining SEQ_SUMMER_SAT_EN adds a clamping adder and a sticky ovf output.
module seq_summer
    import seq_summer_pkg::*;
#(
    parameter int unsigned W  = WDefault,
    parameter int unsigned CW = CwDefault
) (
    input  logic          ck,
    input  logic          reset,
    input  logic          go_l,
    input  logic [W-1:0]  inA,
    output logic [W-1:0]  sum,
    output logic          done,
    output logic          busy,
    output logic [CW-1:0] nterms
`ifdef SEQ_SUMMER_SAT_EN
    ,
    output logic          ovf
`endif
);

    state_t        state_q, state_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [CW-1:0] nterms_q, nterms_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          term_zero;
    logic          nterms_full;
    logic [W-1:0]  add_sum;
`ifdef SEQ_SUMMER_SAT_EN
    logic          add_carry;
    logic          ovf_q, ovf_d;
`else
    logic          add_carry_unused;
`endif

    assign term_zero   = (inA == '0);
    assign nterms_full = &nterms_q;

    seq_summer_add #(
        .W (W)
    ) u_add (
        .a_i     (sum_q),
        .b_i     (inA),
        .sum_o   (add_sum),
`ifdef SEQ_SUMMER_SAT_EN
        .carry_o (add_carry)
`else
        .carry_o (add_carry_unused)
`endif
    );

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        nterms_d = nterms_q;
`ifdef SEQ_SUMMER_SAT_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (!go_l) begin
`ifdef SEQ_SUMMER_SAT_EN
                    ovf_d = 1'b0;
`endif
                    if (term_zero) begin
                        sum_d    = '0;
                        nterms_d = '0;
                        state_d  = DONE;
                    end else begin
                        sum_d    = inA;
                        nterms_d = CW'(1);
                        state_d  = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (term_zero) begin
                    state_d = DONE;
                end else begin
                    sum_d = add_sum;
                    // Term count sticks at all-ones rather than wrapping
                    if (!nterms_full) begin
                        nterms_d = nterms_q + CW'(1);
                    end
`ifdef SEQ_SUMMER_SAT_EN
                    ovf_d = ovf_q | add_carry;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sum_q    <= '0;
            nterms_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SEQ_SUMMER_SAT_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            nterms_q <= nterms_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef SEQ_SUMMER_SAT_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign sum    = sum_q;
    assign nterms = nterms_q;
    assign done   = done_q;
    assign busy   = busy_q;
`ifdef SEQ_SUMMER_SAT_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_seq_summer.sv
// Self-checking bench for seq_summer against an arithmetic model of the
// summing rules; follows SEQ_SUMMER_SAT_EN when it is defined.
module tb_seq_summer;

    localparam int unsigned W      = 8;
    localparam int unsigned CW     = 8;
    localparam int unsigned SumMax = (1 << W) - 1;
    localparam int unsigned NtMax  = (1 << CW) - 1;
`ifdef SEQ_SUMMER_SAT_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    logic          ck = 1'b0;
    logic          reset;
    logic          go_l;
    logic [W-1:0]  inA;
    logic [W-1:0]  sum;
    logic          done;
    logic          busy;
    logic [CW-1:0] nterms;
`ifdef SEQ_SUMMER_SAT_EN
    logic          ovf;
`endif

    int          tests = 0;
    int          fails = 0;
    int unsigned terms[$];
    int unsigned exp_sum, exp_nt;
    bit          exp_ovf;

    always #5 ck = ~ck;

    seq_summer #(
        .W  (W),
        .CW (CW)
    ) dut (
        .ck     (ck),
        .reset  (reset),
        .go_l   (go_l),
        .inA    (inA),
        .sum    (sum),
        .done   (done),
        .busy   (busy),
        .nterms (nterms)
`ifdef SEQ_SUMMER_SAT_EN
        ,
        .ovf    (ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_ovf(input string tag, input bit exp);
`ifdef SEQ_SUMMER_SAT_EN
        check(tag, 64'(ovf), 64'(exp));
`else
        if (exp) $display("note: %s expects ovf but the feature is absent", tag);
`endif
    endtask

    // Reference sum of the first k terms: plain integer sum, then wrap or clamp.
    function automatic int unsigned model_sum(input int k);
        int unsigned acc = 0;
        for (int i = 0; i < k; i++) begin
            acc = acc + terms[i];
            if (acc > SumMax) acc = Sat ? SumMax : acc - (SumMax + 1);
        end
        return acc;
    endfunction

    function automatic bit model_ovf(input int k);
        int unsigned acc = 0;
        bit          hit = 1'b0;
        for (int i = 0; i < k; i++) begin
            acc = acc + terms[i];
            if (acc > SumMax) begin
                hit = 1'b1;
                acc = SumMax;
            end
        end
        return Sat && hit;
    endfunction

    function automatic int unsigned model_nt(input int k);
        return (k > NtMax) ? NtMax : k;
    endfunction

    // Entered at a negedge; returns at a negedge in IDLE with go_l released.
    task automatic run_seq(input string name, input bit hold_go);
        int n;
        n    = terms.size();
        go_l = 1'b0;
        inA  = (n > 0) ? W'(terms[0]) : '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge ck);
            if (n <= 20 || k == n) begin
                check({name, " accum busy"}, 64'(busy), 64'(1));
                check({name, " accum done"}, 64'(done), 64'(0));
                check({name, " accum sum"}, 64'(sum), 64'(model_sum(k)));
                check({name, " accum nterms"}, 64'(nterms), 64'(model_nt(k)));
                check_ovf({name, " accum ovf"}, model_ovf(k));
            end
            go_l = hold_go ? 1'b0 : 1'b1;
            inA  = (k < n) ? W'(terms[k]) : '0;
        end
        @(negedge ck);
        exp_sum = model_sum(n);
        exp_nt  = model_nt(n);
        exp_ovf = model_ovf(n);
        check({name, " done pulse"}, 64'(done), 64'(1));
        check({name, " done busy"}, 64'(busy), 64'(1));
        check({name, " final sum"}, 64'(sum), 64'(exp_sum));
        check({name, " final nterms"}, 64'(nterms), 64'(exp_nt));
        check_ovf({name, " final ovf"}, exp_ovf);
        // go_l low in DONE must not restart
        go_l = 1'b0;
        inA  = W'($urandom_range(1, SumMax));
        @(negedge ck);
        check({name, " idle done"}, 64'(done), 64'(0));
        check({name, " idle busy"}, 64'(busy), 64'(0));
        check({name, " idle sum"}, 64'(sum), 64'(exp_sum));
        check({name, " idle nterms"}, 64'(nterms), 64'(exp_nt));
        check_ovf({name, " idle ovf"}, exp_ovf);
        if (hold_go) begin
            inA = W'(5);
            @(negedge ck);
            check({name, " restart busy"}, 64'(busy), 64'(1));
            check({name, " restart sum"}, 64'(sum), 64'(5));
            check({name, " restart nterms"}, 64'(nterms), 64'(1));
            check_ovf({name, " restart ovf"}, 1'b0);
            go_l = 1'b1;
            inA  = '0;
            @(negedge ck);
            check({name, " restart done"}, 64'(done), 64'(1));
            @(negedge ck);
            check({name, " restart idle"}, 64'(busy), 64'(0));
            exp_sum = 5;
            exp_nt  = 1;
            exp_ovf = 1'b0;
        end
        go_l = 1'b1;
        inA  = '0;
    endtask

    task automatic idle_hold(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            inA  = W'($urandom_range(0, SumMax));
            go_l = 1'b1;
            @(negedge ck);
            check({name, " hold sum"}, 64'(sum), 64'(exp_sum));
            check({name, " hold nterms"}, 64'(nterms), 64'(exp_nt));
            check({name, " hold done"}, 64'(done), 64'(0));
            check({name, " hold busy"}, 64'(busy), 64'(0));
            check_ovf({name, " hold ovf"}, exp_ovf);
        end
        inA = '0;
    endtask

    initial begin
        reset = 1'b1;
        go_l  = 1'b1;
        inA   = '0;
        repeat (2) @(negedge ck);
        check("reset sum", 64'(sum), 64'(0));
        check("reset nterms", 64'(nterms), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check_ovf("reset ovf", 1'b0);

        // go accepted on the first edge after release
        reset = 1'b0;
        terms = '{3, 5, 7};
        run_seq("basic", 1'b0);
        idle_hold("basic", 3);

        terms.delete();
        run_seq("zero", 1'b0);

        terms = '{200, 100};
        run_seq("wrap", 1'b0);
        idle_hold("wrap", 2);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 6);
            terms.delete();
            for (int i = 0; i < n; i++) terms.push_back($urandom_range(1, SumMax));
            run_seq("rand", r == 3);
        end

        terms = '{10, 20};
        run_seq("gohold", 1'b1);
        idle_hold("gohold", 1);

        terms.delete();
        for (int i = 0; i < 260; i++) terms.push_back(1);
        run_seq("ntsat", 1'b0);

        // Asynchronous reset in the middle of an accumulation
        go_l = 1'b0;
        inA  = W'(9);
        @(negedge ck);
        go_l = 1'b1;
        @(negedge ck);
        check("midreset pre sum", 64'(sum), 64'(18));
        check("midreset pre nterms", 64'(nterms), 64'(2));
        #2 reset = 1'b1;
        #1;
        check("midreset sum", 64'(sum), 64'(0));
        check("midreset nterms", 64'(nterms), 64'(0));
        check("midreset busy", 64'(busy), 64'(0));
        check("midreset done", 64'(done), 64'(0));
        check_ovf("midreset ovf", 1'b0);
        @(negedge ck);
        check("midreset held done", 64'(done), 64'(0));
        reset = 1'b0;
        terms = '{4};
        run_seq("postreset", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
